// File: rtl/gsc_bcd_pkg.sv
// Shared BCD digit type, digit limits and the load clamp used by the counter chain.
package gsc_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Non-BCD nibbles (A..F) saturate to 9 so the chain never holds an illegal digit.
    function automatic bcd_digit_t bcd_clamp(input logic [3:0] raw);
        return (raw > BCD_MAX) ? BCD_MAX : raw;
    endfunction

endpackage

// File: rtl/bcd_digit_ud.sv
// One registered up/down BCD digit; counts only when its carry/borrow input is high.
// cout is combinational so a whole chain settles within a single cycle.
module bcd_digit_ud
    import gsc_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cin,
    input  logic       dir,
    input  logic       load,
    input  bcd_digit_t load_dig,
    input  logic       clr,
    output bcd_digit_t dig,
    output logic       cout
);

    bcd_digit_t dig_q;
    bcd_digit_t dig_d;
    logic       at_limit;

    assign at_limit = dir ? (dig_q == BCD_MAX) : (dig_q == BCD_MIN);
    assign cout     = cin & at_limit;
    assign dig      = dig_q;

    always_comb begin
        dig_d = dig_q;
        if (clr) begin
            dig_d = BCD_MIN;
        end else if (load) begin
            dig_d = load_dig;
        end else if (cin) begin
            if (dir) begin
                dig_d = at_limit ? BCD_MIN : (dig_q + 4'd1);
            end else begin
                dig_d = at_limit ? BCD_MAX : (dig_q - 4'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_q <= BCD_MIN;
        end else begin
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/bcd_chain_cnt.sv
// Cascaded up/down BCD counter with sync clear/load, combinational tc and a registered wrap pulse.
// Single-cycle update: q and wrap change on the edge that counts, no pipeline.
module bcd_chain_cnt
    import gsc_bcd_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned UP_ONLY = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap
);

    logic              dir_eff;
    logic [DIGITS:0]   carry;
    bcd_digit_t        dig [DIGITS];
    logic              wrap_q;
    logic              wrap_d;

    assign dir_eff  = (UP_ONLY != 0) ? 1'b1 : dir;
    assign carry[0] = en;

    // Digit 0 is driven by en; each later digit counts only on its neighbour's carry/borrow.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_ud u_digit (
            .clk      (clk),
            .reset_n  (reset_n),
            .cin      (carry[i]),
            .dir      (dir_eff),
            .load     (load),
            .load_dig (bcd_clamp(load_val[4*i +: 4])),
            .clr      (clr),
            .dig      (dig[i]),
            .cout     (carry[i+1])
        );
        assign q[4*i +: 4] = dig[i];
    end

    // Carry out of the top digit is en gated by "every digit at its limit".
    assign tc     = carry[DIGITS];
    assign wrap_d = tc & ~clr & ~load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule
